// File: rtl/branch_predictor_2bit_if.sv
// rtl/branch_predictor_2bit_if.sv - lookup and resolve signal bundle for branch_predictor_2bit (BP_GSHARE_EN adds history ports)
interface branch_predictor_2bit_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int MISS_CNT_BITS = 16,
  parameter int HIST_BITS     = 4
);
  logic [6:0]               if_id_opcode;
  logic [DATA_WIDTH-1:0]    if_pc;
  logic                     prediction;
  logic [DATA_WIDTH-1:0]    branch_target;
  logic                     btb_hit;
  logic [6:0]               ex_mem_opcode;
  logic [DATA_WIDTH-1:0]    ex_mem_pc;
  logic                     ex_mem_branch_taken;
  logic [DATA_WIDTH-1:0]    ex_mem_branch_target;
  logic                     ex_mem_predicted;
  logic [DATA_WIDTH-1:0]    ex_mem_pred_target;
  logic                     prediction_checkout_ex_mem;
  logic                     mispredict;
  logic [MISS_CNT_BITS-1:0] mispredict_count;
`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0]     if_hist;
  logic [HIST_BITS-1:0]     ex_mem_hist;

  modport master (
    output if_id_opcode, if_pc, ex_mem_opcode, ex_mem_pc, ex_mem_branch_taken,
           ex_mem_branch_target, ex_mem_predicted, ex_mem_pred_target, ex_mem_hist,
    input  prediction, branch_target, btb_hit, prediction_checkout_ex_mem,
           mispredict, mispredict_count, if_hist
  );

  modport slave (
    input  if_id_opcode, if_pc, ex_mem_opcode, ex_mem_pc, ex_mem_branch_taken,
           ex_mem_branch_target, ex_mem_predicted, ex_mem_pred_target, ex_mem_hist,
    output prediction, branch_target, btb_hit, prediction_checkout_ex_mem,
           mispredict, mispredict_count, if_hist
  );
`else
  modport master (
    output if_id_opcode, if_pc, ex_mem_opcode, ex_mem_pc, ex_mem_branch_taken,
           ex_mem_branch_target, ex_mem_predicted, ex_mem_pred_target,
    input  prediction, branch_target, btb_hit, prediction_checkout_ex_mem,
           mispredict, mispredict_count
  );

  modport slave (
    input  if_id_opcode, if_pc, ex_mem_opcode, ex_mem_pc, ex_mem_branch_taken,
           ex_mem_branch_target, ex_mem_predicted, ex_mem_pred_target,
    output prediction, branch_target, btb_hit, prediction_checkout_ex_mem,
           mispredict, mispredict_count
  );
`endif
endinterface

// File: rtl/branch_predictor_2bit.sv
// rtl/branch_predictor_2bit.sv - direct-mapped tagged BTB with saturating counters; optional BP_GSHARE_EN history indexing
module branch_predictor_2bit #(
  parameter int DATA_WIDTH    = 32,
  parameter int BRANCH_NO     = 16,
  parameter int TAG_BITS      = 8,
  parameter int CNT_BITS      = 2,
  parameter int MISS_CNT_BITS = 16
`ifdef BP_GSHARE_EN
  ,
  parameter int HIST_BITS     = 4
`endif
) (
  input logic                   i_clk,
  input logic                   i_rst,
  branch_predictor_2bit_if.slave bp
);

  localparam int                 IDX_BITS = $clog2(BRANCH_NO);
  localparam logic [6:0]         B_TYPE   = 7'b1100011;
  localparam logic [CNT_BITS-1:0] CNT_WNT = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic [CNT_BITS-1:0] CNT_WT  = {1'b1, {(CNT_BITS-1){1'b0}}};
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [MISS_CNT_BITS-1:0] MISS_MAX = '1;

  logic                  r_valid  [BRANCH_NO];
  logic [TAG_BITS-1:0]   r_tag    [BRANCH_NO];
  logic [CNT_BITS-1:0]   r_cnt    [BRANCH_NO];
  logic [DATA_WIDTH-1:0] r_target [BRANCH_NO];
  logic [MISS_CNT_BITS-1:0] r_miss_cnt;

  logic [IDX_BITS-1:0]   w_lk_idx;
  logic [IDX_BITS-1:0]   w_up_idx;
  logic [TAG_BITS-1:0]   w_lk_tag;
  logic [TAG_BITS-1:0]   w_up_tag;
  logic                  w_lk_hit;
  logic                  w_lk_pred;
  logic                  w_up_match;
  logic                  w_update;
  logic                  w_mispredict;
  logic                  w_unused_pc;

`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0]  r_ghr;

  assign w_lk_idx   = bp.if_pc[IDX_BITS+1:2] ^ IDX_BITS'(r_ghr);
  assign w_up_idx   = bp.ex_mem_pc[IDX_BITS+1:2] ^ IDX_BITS'(bp.ex_mem_hist);
  assign bp.if_hist = r_ghr;
`else
  assign w_lk_idx   = bp.if_pc[IDX_BITS+1:2];
  assign w_up_idx   = bp.ex_mem_pc[IDX_BITS+1:2];
`endif

  assign w_lk_tag    = bp.if_pc[IDX_BITS+2+TAG_BITS-1:IDX_BITS+2];
  assign w_up_tag    = bp.ex_mem_pc[IDX_BITS+2+TAG_BITS-1:IDX_BITS+2];
  assign w_unused_pc = ^{bp.if_pc, bp.ex_mem_pc};

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign w_lk_hit   = (bp.if_id_opcode == B_TYPE) && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_pred  = w_lk_hit && r_cnt[w_lk_idx][CNT_BITS-1];
  assign w_up_match = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_update   = (bp.ex_mem_opcode == B_TYPE);

  assign w_mispredict = w_update &&
                        ((bp.ex_mem_predicted != bp.ex_mem_branch_taken) ||
                         (bp.ex_mem_predicted && bp.ex_mem_branch_taken &&
                          (bp.ex_mem_pred_target != bp.ex_mem_branch_target)));

  assign bp.btb_hit                    = w_lk_hit;
  assign bp.prediction                 = w_lk_pred;
  assign bp.branch_target              = w_lk_pred ? r_target[w_lk_idx] : '0;
  assign bp.prediction_checkout_ex_mem = w_up_match && r_cnt[w_up_idx][CNT_BITS-1];
  assign bp.mispredict                 = w_mispredict;
  assign bp.mispredict_count           = r_miss_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BRANCH_NO; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_cnt[i]    <= CNT_WNT;
        r_target[i] <= '0;
      end
    end else if (w_update) begin
      r_valid[w_up_idx] <= 1'b1;
      r_tag[w_up_idx]   <= w_up_tag;
      if (w_up_match) begin
        if (bp.ex_mem_branch_taken) begin
          if (r_cnt[w_up_idx] != CNT_MAX) begin
            r_cnt[w_up_idx] <= r_cnt[w_up_idx] + CNT_BITS'(1);
          end
          r_target[w_up_idx] <= bp.ex_mem_branch_target;
        end else if (r_cnt[w_up_idx] != '0) begin
          r_cnt[w_up_idx] <= r_cnt[w_up_idx] - CNT_BITS'(1);
        end
      end else begin
        // Miss always evicts the previous occupant of this slot.
        r_cnt[w_up_idx]    <= bp.ex_mem_branch_taken ? CNT_WT : CNT_WNT;
        r_target[w_up_idx] <= bp.ex_mem_branch_taken ? bp.ex_mem_branch_target : '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_miss_cnt <= '0;
    end else if (w_mispredict && (r_miss_cnt != MISS_MAX)) begin
      r_miss_cnt <= r_miss_cnt + MISS_CNT_BITS'(1);
    end
  end

`ifdef BP_GSHARE_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ghr <= '0;
    end else if (w_update) begin
      r_ghr <= HIST_BITS'({r_ghr, bp.ex_mem_branch_taken});
    end
  end
`endif

endmodule
